// File: rtl/mips_avalon_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single shared slave (RAM).
// m0 is the MIPS instruction-fetch port, m1 the data port. One transaction
// is in flight at a time; each one walks IDLE -> BUSY -> DONE -> GAP so the
// slave always sees a fresh rising read/write strobe per transaction.
//
// Handshake: on each master port, (read | write) is "valid" and
// waitrequest low is "ready". A master holds its request and its
// address/data stable until it samples waitrequest low at a rising edge.
// That edge completes its transaction, and the master may then drop or
// change the request. Waitrequest is low for exactly one cycle per
// transaction, and it does not depend on whether that master is
// currently requesting.
//
// On the slave side, s_read/s_write are "valid" and s_waitrequest low is
// "ready". The slave's ready is only honoured from the second BUSY cycle
// onward.
module mips_avalon_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic [31:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,

  input  logic [31:0] m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,

  output logic [31:0] s_address,
  output logic [3:0]  s_byteenable,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,

  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          req0;
  logic          req1;
  logic          win_sel;     // 0 = m0, 1 = m1
  logic          grant;       // master owning the current transaction
  logic          last_grant;  // master granted most recently
  logic [CW-1:0] busy_cnt;    // number of the BUSY cycle in progress (1-based)

  logic [31:0]   lat_addr;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wdata;
  logic          lat_write;

  logic          xfer_ok;
  logic          xfer_abort;

  logic [31:0]   m0_rdata_q;
  logic [31:0]   m1_rdata_q;
  logic          timeout_q;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Round-robin pick. On a tie the master not granted last wins.
  // With a single requester, that requester wins.
  always_comb begin
    win_sel = 1'b0;
    if (req0 && req1) begin
      win_sel = ~last_grant;
    end else begin
      win_sel = req1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic plus the completion and abort strobes seen by the datapath.
  always_comb begin
    state_nxt  = state;
    xfer_ok    = 1'b0;
    xfer_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // The slave's ready is ignored in the first BUSY cycle so that the
        // strobe is seen for at least one full cycle.
        if ((busy_cnt != CNT_ONE) && !s_waitrequest) begin
          xfer_ok   = 1'b1;
          state_nxt = ST_DONE;
        end else if (busy_cnt == CNT_LAST) begin
          xfer_abort = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winning request and track round-robin history on a new grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= 1'b1;
      last_grant <= 1'b1;
      lat_addr   <= '0;
      lat_be     <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
    end else if ((state == ST_IDLE) && (req0 || req1)) begin
      grant      <= win_sel;
      last_grant <= win_sel;
      lat_addr   <= win_sel ? m1_address    : m0_address;
      lat_be     <= win_sel ? m1_byteenable : m0_byteenable;
      lat_wdata  <= win_sel ? m1_writedata  : m0_writedata;
      // A write strobe takes precedence when a master raises read and write together.
      lat_write  <= win_sel ? m1_write      : m0_write;
    end
  end

  // Count BUSY cycles. The count restarts at 1 on entry to BUSY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt <= '0;
    end else if ((state == ST_IDLE) && (state_nxt == ST_BUSY)) begin
      busy_cnt <= CNT_ONE;
    end else if ((state == ST_BUSY) && (state_nxt == ST_BUSY)) begin
      busy_cnt <= busy_cnt + CNT_ONE;
    end else if (state != ST_BUSY) begin
      busy_cnt <= '0;
    end
  end

  // Capture read data into the granted master's register when a read
  // completes, or zero it when a read is aborted. A write leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else if ((xfer_ok || xfer_abort) && !lat_write) begin
      if (grant) begin
        m1_rdata_q <= xfer_ok ? s_readdata : 32'h0;
      end else begin
        m0_rdata_q <= xfer_ok ? s_readdata : 32'h0;
      end
    end
  end

  // Sticky abort flag. Only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else if (xfer_abort) begin
      timeout_q <= 1'b1;
    end
  end

  assign s_address      = lat_addr;
  assign s_byteenable   = lat_be;
  assign s_writedata    = lat_wdata;
  assign s_read         = (state == ST_BUSY) && !lat_write;
  assign s_write        = (state == ST_BUSY) &&  lat_write;

  assign m0_waitrequest = !((state == ST_DONE) && (grant == 1'b0));
  assign m1_waitrequest = !((state == ST_DONE) && (grant == 1'b1));
  assign m0_readdata    = m0_rdata_q;
  assign m1_readdata    = m1_rdata_q;

  assign timeout_err    = timeout_q;
  assign dbg_state      = state;

endmodule

// File: doc/mips_avalon_arbiter.md
MIPS_AVALON_ARBITER -- requirements
Module: mips_avalon_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum BUSY cycles before a transaction is aborted.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, inputs, widths 32/4/1/1/32: instruction-fetch master request.
REQ-005 SHALL have ports m0_waitrequest (1 bit) and m0_readdata (32 bits), outputs: instruction-fetch master response.
REQ-006 SHALL have ports m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, inputs, widths 32/4/1/1/32: data master request.
REQ-007 SHALL have ports m1_waitrequest (1 bit) and m1_readdata (32 bits), outputs: data master response.
REQ-008 SHALL have ports s_address, s_byteenable, s_read, s_write, s_writedata, outputs, widths 32/4/1/1/32: shared Avalon slave (RAM) request.
REQ-009 SHALL have ports s_waitrequest (1 bit) and s_readdata (32 bits), inputs: shared slave response.
REQ-010 SHALL have port timeout_err, output, 1 bit: sticky abort flag.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE, GAP.
REQ-012 IDLE: a master is requesting when read|write is high; if any request exists, SHALL latch the winner's address, byteenable, writedata and op into registers, and SHALL enter BUSY next cycle.
REQ-013 Arbitration SHALL be round-robin; when both masters request, the one not granted last SHALL win; last-grant SHALL reset to m1, so m0 wins first.
REQ-014 If a master asserts read and write together, it SHALL be treated as a write.
REQ-015 s_address, s_byteenable and s_writedata SHALL be driven from the latched registers; s_read or s_write SHALL be high only in BUSY.
REQ-016 BUSY: from the second BUSY cycle onward, s_waitrequest low SHALL complete the transaction; for a read, s_readdata SHALL be captured into the granted master's readdata register; next state DONE.
REQ-017 BUSY: if TIMEOUT_CYCLES BUSY cycles elapse without completion, SHALL abort, load readdata with 0, set timeout_err, and enter DONE.
REQ-018 DONE: granted master's waitrequest SHALL be low for exactly one cycle; next state GAP.
REQ-019 GAP: s_read and s_write SHALL be low for one cycle so the slave sees a fresh rising strobe per transaction; next state IDLE.
REQ-020 mK_waitrequest SHALL be high in every cycle except DONE with grant==K; it is independent of whether mK is requesting.
REQ-021 mK_readdata SHALL hold its last captured value until the next read completes for mK; a write SHALL not change it.
REQ-022 Minimum latency: request seen in IDLE at cycle N; waitrequest low at cycle N+3 when s_waitrequest is low in BUSY cycle 2; back-to-back issue spacing SHALL be at least 4 cycles.
REQ-023 Requests arriving during BUSY, DONE or GAP SHALL be held by the masters (Avalon rule) and arbitrated at the next IDLE; none SHALL be dropped.
REQ-024 timeout_err SHALL stay high until reset once set.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, s_read=0, s_write=0, s_address/s_byteenable/s_writedata=0, m0/m1_waitrequest=1, m0/m1_readdata=0, timeout_err=0, last-grant=m1, timeout counter=0.
REQ-026 Reset asserted mid-BUSY SHALL abandon the transaction with no completion to either master; after release, new requests SHALL be arbitrated from IDLE.

Verification
REQ-027 m0 reads 0xBFC00000 alone, slave waitrequest low in BUSY cycle 2, s_readdata=0x24020005 -> m0_waitrequest low at N+3, m0_readdata=0x24020005, m1_waitrequest stays 1.
REQ-028 m0 and m1 request together every cycle -> grants alternate m0, m1, m0, m1; s_read/s_write low in every GAP cycle.
REQ-029 m1 writes 0x12345678 with byteenable 4'b0011 -> s_write high for the BUSY cycles only, s_writedata=0x12345678, s_byteenable=0011, m1_readdata unchanged.
REQ-030 With TIMEOUT_CYCLES=8 and s_waitrequest held high -> abort after 8 BUSY cycles, m0_readdata=0, one-cycle waitrequest low, timeout_err=1 until reset.
REQ-031 reset_n pulsed low during BUSY -> s_read drops asynchronously, all REQ-025 values observed; a subsequent m1 request completes normally.
REQ-032 m1 read and write both high -> treated as write: s_write=1, s_read=0.
